// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel pulse generator.
package pulse_gen_pkg;

  // Per-channel sequencing state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chan_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Power-on waveform: a divide-by-two strobe.
  localparam int DEF_PERIOD_RST = 2;
  localparam int DEF_WIDTH_RST  = 1;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int ch_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: IDLE/HIGH/LOW sequencer, a single down-counter and
// shadow/active configuration so a running period is never disturbed.
module pulse_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = DEF_PERIOD_RST,
  parameter int DEF_WIDTH  = DEF_WIDTH_RST
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic             cfg_mode,
  output logic             pulse,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_per_q, act_per_d;
  logic [CNT_W-1:0] act_wid_q, act_wid_d;
  logic             act_mode_q, act_mode_d;
  logic [CNT_W-1:0] sh_per_q, sh_wid_q;
  logic             sh_mode_q;
  logic             pulse_q, busy_q;

  logic             begin_period, end_period;
  logic [CNT_W-1:0] act_hi, sh_hi;

  // Effective high time is clipped to the period (width >= period => all high).
  assign act_hi = (act_wid_q > act_per_q) ? act_per_q : act_wid_q;
  assign sh_hi  = (sh_wid_q  > sh_per_q)  ? sh_per_q  : sh_wid_q;

  // Next-state logic: counter holds remaining cycles of the current state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_per_d    = act_per_q;
    act_wid_d    = act_wid_q;
    act_mode_d   = act_mode_q;
    begin_period = 1'b0;
    end_period   = 1'b0;

    case (state_q)
      IDLE: begin
        // Active config tracks the shadow while nothing is running.
        act_per_d  = sh_per_q;
        act_wid_d  = sh_wid_q;
        act_mode_d = sh_mode_q;
        cnt_d      = '0;
        if (sh_per_q != '0 && (sh_mode_q == MODE_PERIODIC || start)) begin
          begin_period = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q <= ONE) begin
          if (act_per_q != act_hi) begin
            state_d = LOW;
            cnt_d   = act_per_q - act_hi;
          end else begin
            end_period = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      LOW: begin
        if (cnt_q <= ONE) begin
          end_period = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Period boundary: one-shots finish, periodic channels restart.
    if (end_period) begin
      if (act_mode_q == MODE_ONESHOT || sh_mode_q == MODE_ONESHOT) begin
        state_d    = IDLE;
        cnt_d      = '0;
        act_per_d  = sh_per_q;
        act_wid_d  = sh_wid_q;
        act_mode_d = sh_mode_q;
      end else begin
        begin_period = 1'b1;
      end
    end

    // A new period always starts from the latest shadow values.
    if (begin_period) begin
      act_per_d  = sh_per_q;
      act_wid_d  = sh_wid_q;
      act_mode_d = sh_mode_q;
      if (sh_per_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (sh_wid_q == '0) begin
        state_d = LOW;
        cnt_d   = sh_per_q;
      end else begin
        state_d = HIGH;
        cnt_d   = sh_hi;
      end
    end

    // Dropping enable wins over every other event.
    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      act_per_d  = sh_per_q;
      act_wid_d  = sh_wid_q;
      act_mode_d = sh_mode_q;
    end
  end

  // State, counter, config and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      act_per_q  <= CNT_W'(DEF_PERIOD);
      act_wid_q  <= CNT_W'(DEF_WIDTH);
      act_mode_q <= MODE_PERIODIC;
      sh_per_q   <= CNT_W'(DEF_PERIOD);
      sh_wid_q   <= CNT_W'(DEF_WIDTH);
      sh_mode_q  <= MODE_PERIODIC;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_per_q  <= act_per_d;
      act_wid_q  <= act_wid_d;
      act_mode_q <= act_mode_d;
      if (cfg_we) begin
        sh_per_q  <= cfg_period;
        sh_wid_q  <= cfg_width;
        sh_mode_q <= cfg_mode;
      end
      pulse_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// NUM_CH independent pulse channels sharing one configuration port.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = DEF_PERIOD_RST,
  parameter int DEF_WIDTH  = DEF_WIDTH_RST,
  localparam int CH_W      = ch_sel_width(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] start,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] ch_we;

  // Channel-select decode; out-of-range selects match no channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign ch_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

    pulse_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_WIDTH  (DEF_WIDTH)
    ) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable[gi]),
      .start      (start[gi]),
      .cfg_we     (ch_we[gi]),
      .cfg_period (cfg_period),
      .cfg_width  (cfg_width),
      .cfg_mode   (cfg_mode),
      .pulse      (pulse[gi]),
      .busy       (busy[gi])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed scoreboard bench for pulse_gen_multi (3 channels, so an
// out-of-range channel select is representable on the 2-bit cfg_ch).
module tb_pulse_gen_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] enable = '0;
  logic [NCH-1:0] start = '0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic [CW-1:0]  cfg_width = '0;
  logic           cfg_mode = 1'b0;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] busy;

  pulse_gen_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_mode   (cfg_mode),
    .pulse      (pulse),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] pul;
    logic [NCH-1:0] bsy;
    string          name;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [NCH-1:0] mask,
                       input logic [NCH-1:0] ep, input logic [NCH-1:0] eb);
    vectors++;
    if ((((pulse ^ ep) & mask) !== '0) || (((busy ^ eb) & mask) !== '0)) begin
      miscompares++;
      $display("FAIL %s cyc=%0d pulse=%b busy=%b expected pulse=%b busy=%b mask=%b",
               nm, cyc, pulse, busy, ep, eb, mask);
    end else begin
      $display("ok   %s cyc=%0d pulse=%b busy=%b", nm, cyc, pulse, busy);
    end
  endtask

  // Expected outputs rel cycles after the current one, all channels.
  task automatic push(input int rel, input logic [NCH-1:0] p,
                      input logic [NCH-1:0] b, input string nm);
    exp_t e;
    e.cyc = cyc + rel; e.mask = '1; e.pul = p; e.bsy = b; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic cfg(input int ch, input int per, input int wid, input logic mode);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = CW'(per);
    cfg_width = CW'(wid); cfg_mode = mode;
    tick();
    cfg_we = 1'b0;
  endtask

  // Monitor: compare every queued expectation on the cycle it falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL %s missed expectation for cyc=%0d at cyc=%0d", e.name, e.cyc, cyc);
        end else begin
          check(e.name, e.mask, e.pul, e.bsy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NCH-1:0] p;
    logic [NCH-1:0] b;

    // Reset state while reset_n is held low.
    tick(); tick();
    push(1, 3'b000, 3'b000, "reset_state");
    tick();
    reset_n = 1'b1;
    tick();

    // 1: default 2/1 periodic on ch0.
    enable = 3'b001;
    for (int i = 1; i <= 8; i++) begin
      p = '0; p[0] = (i % 2 == 1);
      push(i, p, 3'b001, "dflt_ch0");
    end
    repeat (8) tick();
    enable = 3'b000;
    push(1, 3'b000, 3'b000, "dflt_off");
    tick();

    // 2: ch1 periodic 5/2, five periods.
    cfg(1, 5, 2, 1'b0);
    enable = 3'b010;
    for (int i = 1; i <= 25; i++) begin
      p = '0; p[1] = (((i - 1) % 5) < 2);
      push(i, p, 3'b010, "per_5_2");
    end
    repeat (25) tick();

    // 4: rewrite ch1 to 3/1 during HIGH; current period finishes at 5/2.
    for (int j = 1; j <= 12; j++) begin
      p = '0;
      p[1] = (j <= 5) ? ((j - 1) < 2) : (((j - 6) % 3) == 0);
      push(j, p, 3'b010, "live_recfg");
    end
    tick();
    cfg(1, 3, 1, 1'b0);
    repeat (10) tick();
    enable = 3'b000;
    push(1, 3'b000, 3'b000, "recfg_off");
    tick();

    // 3: ch2 one-shot 4/3, retrigger while busy ignored.
    cfg(2, 4, 3, 1'b1);
    enable = 3'b100;
    push(1, 3'b000, 3'b000, "os_wait");
    tick();
    for (int i = 1; i <= 3; i++) push(i, 3'b100, 3'b100, "os_high");
    push(4, 3'b000, 3'b100, "os_low");
    for (int i = 5; i <= 7; i++) push(i, 3'b000, 3'b000, "os_idle");
    start = 3'b100; tick();
    start = 3'b000; tick();
    start = 3'b100; tick();
    start = 3'b000;
    repeat (4) tick();

    // Start and config write together: old 4/3 first, then new 6/1.
    for (int i = 1; i <= 3; i++) push(i, 3'b100, 3'b100, "os_old_high");
    push(4, 3'b000, 3'b100, "os_old_low");
    push(5, 3'b000, 3'b000, "os_old_idle");
    start = 3'b100;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd6; cfg_width = 8'd1; cfg_mode = 1'b1;
    tick();
    start = 3'b000; cfg_we = 1'b0;
    repeat (4) tick();
    push(1, 3'b100, 3'b100, "os_new_high");
    for (int i = 2; i <= 6; i++) push(i, 3'b000, 3'b100, "os_new_low");
    push(7, 3'b000, 3'b000, "os_new_idle");
    start = 3'b100; tick();
    start = 3'b000;
    repeat (6) tick();
    enable = 3'b000;
    tick();

    // 5: boundaries on ch0.
    cfg(0, 3, 0, 1'b0);
    enable = 3'b001;
    for (int i = 1; i <= 6; i++) push(i, 3'b000, 3'b001, "wid0");
    repeat (6) tick();
    enable = 3'b000;
    push(1, 3'b000, 3'b000, "wid0_off");
    tick();

    cfg(0, 4, 7, 1'b0);
    enable = 3'b001;
    for (int i = 1; i <= 8; i++) push(i, 3'b001, 3'b001, "wid_ge_per");
    repeat (8) tick();
    enable = 3'b000;
    tick();

    cfg(0, 0, 3, 1'b0);
    enable = 3'b001;
    for (int i = 1; i <= 4; i++) push(i, 3'b000, 3'b000, "per0");
    repeat (4) tick();
    enable = 3'b000;

    // Out-of-range select must leave every channel as it was.
    cfg(0, 2, 1, 1'b0);
    cfg(3, 5, 5, 1'b0);
    enable = 3'b111;
    start  = 3'b100;
    for (int i = 1; i <= 6; i++) begin
      p[0] = (i % 2 == 1);
      p[1] = (((i - 1) % 3) == 0);
      p[2] = (i == 1);
      push(i, p, 3'b111, "bad_ch");
    end
    tick();
    start = 3'b000;
    repeat (5) tick();
    enable = 3'b000;
    push(1, 3'b000, 3'b000, "all_off");
    tick();

    // 6: abort by enable mid-HIGH.
    cfg(1, 8, 5, 1'b0);
    enable = 3'b010;
    push(1, 3'b010, 3'b010, "abort_high");
    push(2, 3'b010, 3'b010, "abort_high");
    push(3, 3'b000, 3'b000, "abort_en");
    repeat (2) tick();
    enable = 3'b000;
    tick();

    // Abort by asynchronous reset mid-HIGH.
    enable = 3'b010;
    push(1, 3'b010, 3'b010, "pre_reset");
    push(2, 3'b010, 3'b010, "pre_reset");
    repeat (2) tick();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    b = '0;
    check("async_reset", 3'b111, 3'b000, b);
    tick();
    enable = 3'b000;
    push(1, 3'b000, 3'b000, "reset_hold");
    tick();
    reset_n = 1'b1;
    tick();
    enable = 3'b010;
    for (int i = 1; i <= 4; i++) begin
      p = '0; p[1] = (i % 2 == 1);
      push(i, p, 3'b010, "post_reset_dflt");
    end
    repeat (4) tick();
    enable = 3'b000;
    repeat (2) tick();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
- Parametrised successor to the single free-running clock/pulse pair.
- Provides NUM_CH independent, clock-synchronous pulse channels. Each channel has a programmable period, pulse width and mode (periodic or one-shot).
- Used as the stimulus/timing source for bench and datapath blocks that need gated strobes, divided clocks or trigger pulses. Replaces ad-hoc delay-based pulse generation with fully registered outputs.

Parameters:
- NUM_CH, 4, number of independent pulse channels (1..16)
- CNT_W, 8, width of the period/width counters in clock cycles
- DEF_PERIOD, 2, period loaded into every channel at reset
- DEF_WIDTH, 1, high-time loaded into every channel at reset

Ports:
- clock  in  1  system clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  NUM_CH  per-channel run enable (level)
- start  in  NUM_CH  per-channel one-shot trigger, sampled on rising clock edge
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  clog2(NUM_CH) (min 1)  channel selected by cfg_we
- cfg_period  in  CNT_W  period in cycles
- cfg_width  in  CNT_W  high-time in cycles
- cfg_mode  in  1  0 = periodic, 1 = one-shot
- pulse  out  NUM_CH  registered pulse outputs
- busy  out  NUM_CH  channel currently in HIGH or LOW state

Behaviour:
- Reset:
  - Asserting reset_n low immediately clears pulse and busy to 0, forces every channel to IDLE and zeroes the counters.
  - Active registers take period=DEF_PERIOD, width=DEF_WIDTH, mode=periodic. Shadow registers take the same values.
  - Reset mid-pulse truncates the pulse at once.
- Configuration:
  - A cfg_we edge writes cfg_period, cfg_width and cfg_mode into the shadow registers of channel cfg_ch.
  - The active registers copy the shadow only in IDLE, or at a period boundary (the last LOW cycle → next HIGH). A running waveform is therefore never disturbed mid-period.
  - cfg_ch >= NUM_CH: the write is ignored.
- Per-channel FSM, states IDLE, HIGH, LOW:
  - IDLE → HIGH, periodic mode: enable=1 and period!=0.
  - IDLE → HIGH, one-shot mode: enable=1, start=1 and period!=0.
  - pulse goes to 1 on the same edge that leaves IDLE, i.e. one cycle of latency from the sampled input.
  - HIGH lasts exactly width cycles, then → LOW.
  - LOW lasts period-width cycles. At its end: periodic mode → HIGH; one-shot mode → IDLE.
  - width=0: HIGH is skipped and pulse stays 0, but the channel still cycles through LOW for period cycles (busy=1).
  - width >= period: periodic output is a constant 1 while enabled. A one-shot gives a single pulse of period cycles.
  - period=0: the channel stays in IDLE.
- Counter: a single CNT_W down-counter per channel, reloaded on each state entry. No overflow is possible because loads are <= 2^CNT_W-1.
- Simultaneous events:
  - enable=0 has priority over everything else: the channel returns to IDLE at the next edge and pulse=0 after that edge.
  - start while busy is ignored, with no retrigger and no queueing.
  - start and cfg_we to the same channel in the same cycle: the pulse uses the old active values (the shadow is not yet loaded). The new values apply to the next start.
- busy = (state != IDLE), registered together with pulse.
- Channels are fully independent and share no counters.

Decomposition:
- Package pulse_gen_pkg:
  - state enum {IDLE, HIGH, LOW}
  - MODE_PERIODIC / MODE_ONESHOT constants
  - DEF_* defaults
- Sub-module pulse_chan:
  - one channel holding the FSM, down-counter and shadow/active config registers
  - instantiated NUM_CH times with a generate loop in pulse_gen_multi
- The top level contains only the cfg_ch decode and the port concatenation.

Test Plan:
1. Reset defaults: release reset_n, set enable[0]=1 with no config. pulse[0] toggles 1,0,1,0 every cycle (period 2, width 1) and busy[0]=1 from the cycle after enable.
2. Periodic programming: write ch1 period=5, width=2, mode=0, then set enable[1]=1. pulse[1] shows the pattern 1,1,0,0,0 repeating. Measure 5 periods; all other channels are unaffected.
3. One-shot: write ch2 period=4, width=3, mode=1, enable[2]=1, then start[2] for 1 cycle. pulse[2]=1 for exactly 3 cycles and busy[2] for 4, then IDLE. A second start during busy produces no extra pulse.
4. Live reconfiguration: ch1 is running at 5/2 and ch1 is rewritten to 3/1 mid-HIGH. The current period completes as 1,1,0,0,0, and the next period is 1,0,0.
5. Boundaries:
   - width=0, period=3: pulse stays 0 and busy=1.
   - width=7, period=4: pulse is a constant 1.
   - period=0: busy stays 0.
   - cfg_ch=NUM_CH: no channel changes.
6. Abort: drop enable mid-HIGH → pulse=0 and busy=0 one edge later. Assert reset_n low mid-pulse → pulse=0 immediately with no clock edge, and the config reverts to defaults.
